// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard unit.
package fwd_pkg;

   localparam int FWD_REG_W     = 4;
   // Entry tags are stored at this width and zero-extended; REG_W must not exceed it.
   localparam int FWD_REG_W_MAX = 8;
   localparam int FWD_SEL_RF    = 0;

   typedef logic [FWD_REG_W_MAX-1:0] fwd_tag_t;

   typedef struct packed {
      logic     valid;
      fwd_tag_t rd;
      logic     we;
      logic     is_load;
      logic     is_store;
      fwd_tag_t src1;
   } fwd_entry_t;

   localparam fwd_entry_t FWD_BUBBLE = '0;

endpackage

// File: rtl/fwd_src_match.sv
// Priority match of one EX source against the older pipeline stages; youngest producer wins.
module fwd_src_match
   import fwd_pkg::*;
#(
   parameter int DEPTH      = 3,
   parameter int LOAD_STAGE = 2,
   parameter int SEL_W      = 2
) (
   input  logic [DEPTH-1:1]            valid,
   input  logic [DEPTH-1:1]            we,
   input  logic [DEPTH-1:1]            is_load,
   input  logic [DEPTH-1:1][FWD_REG_W_MAX-1:0] rd,
   input  fwd_tag_t                    src,
   input  logic                        src_used,
   output logic [SEL_W-1:0]            sel
);

   localparam int unsigned DEPTH_U = DEPTH;
   localparam int unsigned LS_U    = LOAD_STAGE;

   logic found;

   always_comb begin
      sel   = SEL_W'(FWD_SEL_RF);
      found = 1'b0;
      for (int unsigned k = 1; k < DEPTH_U; k++) begin
         if (!found && valid[k] && we[k] && rd[k] != '0 && rd[k] == src && src_used &&
             (!is_load[k] || k >= LS_U)) begin
            sel   = SEL_W'(k);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding selects, load-use stall and MEM-to-MEM store forwarding from an in-flight tag pipeline.
// Optional statistics counters are built when FWD_HAZARD_STATS_EN is defined.
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter  int REG_W      = FWD_REG_W,
   parameter  int NUM_SRC    = 2,
   parameter  int DEPTH      = 3,
   parameter  int LOAD_STAGE = 2,
   localparam int SEL_W      = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     id_valid,
   input  logic [NUM_SRC*REG_W-1:0] id_src,
   input  logic [NUM_SRC-1:0]       id_src_used,
   input  logic [REG_W-1:0]         id_rd,
   input  logic                     id_rd_we,
   input  logic                     id_is_load,
   input  logic                     id_is_store,
   input  logic                     ext_stall,
   input  logic                     flush,
   output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
   output logic                     load_use_stall,
`ifdef FWD_HAZARD_STATS_EN
   output logic [15:0]              stat_stall_cnt,
   output logic [15:0]              stat_fwd_cnt,
`endif
   output logic                     mem_fwd
);

   localparam int unsigned DEPTH_U = DEPTH;
   localparam int unsigned NSRC_U  = NUM_SRC;
   localparam int unsigned LS_U    = LOAD_STAGE;
   localparam logic [NUM_SRC-1:0] DATA_SRC_ONLY = NUM_SRC'(2);

   fwd_entry_t                entry [DEPTH];
   fwd_tag_t [NUM_SRC-1:0]    ex_src;
   logic [NUM_SRC-1:0]        ex_src_used;
   fwd_tag_t [NUM_SRC-1:0]    id_tag;
   logic [NUM_SRC-1:0]        hit;
   logic                      admit;

   logic [DEPTH-1:1]                    stg_valid;
   logic [DEPTH-1:1]                    stg_we;
   logic [DEPTH-1:1]                    stg_load;
   logic [DEPTH-1:1][FWD_REG_W_MAX-1:0] stg_rd;

   always_comb begin
      id_tag = '0;
      for (int unsigned i = 0; i < NSRC_U; i++)
         id_tag[i] = fwd_tag_t'(id_src[i*REG_W +: REG_W]);
   end

   // The store exemption only applies when the data register alone hits the
   // load one stage short of availability; mem_fwd then supplies the data.
   always_comb begin
      load_use_stall = 1'b0;
      hit            = '0;
      for (int unsigned j = 0; j < DEPTH_U; j++) begin
         for (int unsigned i = 0; i < NSRC_U; i++)
            hit[i] = id_valid && id_src_used[i] && id_tag[i] != '0 &&
                     entry[j].valid && entry[j].is_load && id_tag[i] == entry[j].rd;
         if (j + 1 < LS_U && hit != '0 &&
             !(id_is_store && hit == DATA_SRC_ONLY && j + 1 == LS_U - 1))
            load_use_stall = 1'b1;
      end
   end

   assign mem_fwd = entry[1].valid && entry[1].is_store && entry[2].valid && entry[2].is_load &&
                    entry[2].rd == entry[1].src1 && entry[1].src1 != '0;

   assign admit = id_valid && !flush && !load_use_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < DEPTH_U; k++)
            entry[k] <= FWD_BUBBLE;
         ex_src      <= '0;
         ex_src_used <= '0;
      end else if (!ext_stall) begin
         for (int unsigned k = 1; k < DEPTH_U; k++)
            entry[k] <= entry[k-1];
         if (admit) begin
            entry[0]    <= '{valid: 1'b1, rd: fwd_tag_t'(id_rd), we: id_rd_we,
                             is_load: id_is_load, is_store: id_is_store, src1: id_tag[1]};
            ex_src      <= id_tag;
            ex_src_used <= id_src_used;
         end else begin
            entry[0]    <= FWD_BUBBLE;
            ex_src      <= '0;
            ex_src_used <= '0;
         end
      end
   end

   always_comb begin
      stg_valid = '0;
      stg_we    = '0;
      stg_load  = '0;
      stg_rd    = '0;
      for (int unsigned k = 1; k < DEPTH_U; k++) begin
         stg_valid[k] = entry[k].valid;
         stg_we[k]    = entry[k].we;
         stg_load[k]  = entry[k].is_load;
         stg_rd[k]    = entry[k].rd;
      end
   end

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_src_match #(
         .DEPTH      (DEPTH),
         .LOAD_STAGE (LOAD_STAGE),
         .SEL_W      (SEL_W)
      ) u_match (
         .valid    (stg_valid),
         .we       (stg_we),
         .is_load  (stg_load),
         .rd       (stg_rd),
         .src      (ex_src[i]),
         .src_used (ex_src_used[i]),
         .sel      (fwd_sel[i*SEL_W +: SEL_W])
      );
   end

`ifdef FWD_HAZARD_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_stall_cnt <= '0;
         stat_fwd_cnt   <= '0;
      end else if (!ext_stall) begin
         if (load_use_stall && stat_stall_cnt != '1)
            stat_stall_cnt <= stat_stall_cnt + 16'd1;
         if ((fwd_sel != '0 || mem_fwd) && stat_fwd_cnt != '1)
            stat_fwd_cnt <= stat_fwd_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Random-stimulus scoreboard bench for fwd_hazard_unit in two configurations (3/2 and 5/3).
`timescale 1ns/1ps
module tb_fwd_hazard_unit;

   localparam int RW = 4;
   localparam int NS = 2;

   typedef struct packed {
      logic          valid;
      logic          we;
      logic          ld;
      logic          st;
      logic [RW-1:0] rd;
      logic [RW-1:0] src0;
      logic [RW-1:0] src1;
      logic          used0;
      logic          used1;
   } rec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   for (genvar c = 0; c < 2; c++) begin : g_cfg
      localparam int D  = (c == 0) ? 3 : 5;
      localparam int LS = (c == 0) ? 2 : 3;
      localparam int SW = $clog2(D);

      logic rst, id_valid, id_rd_we, id_is_load, id_is_store, ext_stall, flush;
      logic [NS*RW-1:0] id_src;
      logic [NS-1:0]    id_src_used;
      logic [RW-1:0]    id_rd;
      logic [NS*SW-1:0] fwd_sel;
      logic             load_use_stall, mem_fwd;
`ifdef FWD_HAZARD_STATS_EN
      logic [15:0]      s_stall, s_fwd;
`endif

      bit done = 1'b0;
      logic [NS*SW-1:0] q_sel [$];
      bit               q_stall [$];
      bit               q_mem [$];
      rec_t             hist [$];

      fwd_hazard_unit #(
         .REG_W      (RW),
         .NUM_SRC    (NS),
         .DEPTH      (D),
         .LOAD_STAGE (LS)
      ) dut (
         .clk            (clk),
         .rst            (rst),
         .id_valid       (id_valid),
         .id_src         (id_src),
         .id_src_used    (id_src_used),
         .id_rd          (id_rd),
         .id_rd_we       (id_rd_we),
         .id_is_load     (id_is_load),
         .id_is_store    (id_is_store),
         .ext_stall      (ext_stall),
         .flush          (flush),
         .fwd_sel        (fwd_sel),
         .load_use_stall (load_use_stall),
`ifdef FWD_HAZARD_STATS_EN
         .stat_stall_cnt (s_stall),
         .stat_fwd_cnt   (s_fwd),
`endif
         .mem_fwd        (mem_fwd)
      );

      initial begin : stim
         rec_t             cur;
         bit               exp_stall;
         bit               exp_mem;
         bit               h0, h1;
         logic [NS*SW-1:0] exp_sel;
         logic [RW-1:0]    s;
         bit               u;

         exp_stall   = 1'b0;
         rst         = 1'b1;
         id_valid    = 1'b0;
         id_src      = '0;
         id_src_used = '0;
         id_rd       = '0;
         id_rd_we    = 1'b0;
         id_is_load  = 1'b0;
         id_is_store = 1'b0;
         ext_stall   = 1'b0;
         flush       = 1'b0;

         for (int unsigned n = 0; n < 700; n++) begin
            @(posedge clk);
            #1;
            // Model: the instruction sequence in EX and beyond is a history queue.
            if (rst) begin
               hist.delete();
               repeat (D) hist.push_back('0);
            end else if (!ext_stall) begin
               cur = '0;
               if (id_valid && !flush && !exp_stall) begin
                  cur.valid = 1'b1;
                  cur.we    = id_rd_we;
                  cur.ld    = id_is_load;
                  cur.st    = id_is_store;
                  cur.rd    = id_rd;
                  cur.src0  = id_src[RW-1:0];
                  cur.src1  = id_src[2*RW-1:RW];
                  cur.used0 = id_src_used[0];
                  cur.used1 = id_src_used[1];
               end
               hist.push_front(cur);
               void'(hist.pop_back());
            end

            rst       = (n < 2) || ($urandom_range(0, 59) == 0);
            id_valid  = ($urandom_range(0, 9) != 0);
            ext_stall = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 11) == 0);
            id_rd     = RW'($urandom_range(0, 3));
            id_src    = {RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3))};
            case ($urandom_range(0, 9))
               0, 1, 2: begin
                  id_is_load = 1'b1; id_is_store = 1'b0; id_rd_we = 1'b1; id_src_used = 2'b01;
               end
               3, 4: begin
                  id_is_load = 1'b0; id_is_store = 1'b1; id_rd_we = 1'b0; id_src_used = 2'b11;
               end
               default: begin
                  id_is_load  = 1'b0;
                  id_is_store = 1'b0;
                  id_rd_we    = ($urandom_range(0, 7) != 0);
                  id_src_used = 2'($urandom_range(0, 3));
               end
            endcase

            exp_sel = '0;
            for (int i = 0; i < NS; i++) begin
               s = (i == 0) ? hist[0].src0 : hist[0].src1;
               u = (i == 0) ? hist[0].used0 : hist[0].used1;
               if (u && s != 0) begin
                  for (int k = 1; k < D; k++) begin
                     if (hist[k].valid && hist[k].we && hist[k].rd == s && (!hist[k].ld || k >= LS)) begin
                        exp_sel[i*SW +: SW] = SW'(k);
                        break;
                     end
                  end
               end
            end

            exp_stall = 1'b0;
            if (id_valid) begin
               for (int j = 0; j + 1 < LS; j++) begin
                  if (hist[j].valid && hist[j].ld) begin
                     h0 = id_src_used[0] && id_src[RW-1:0] != 0 && id_src[RW-1:0] == hist[j].rd;
                     h1 = id_src_used[1] && id_src[2*RW-1:RW] != 0 && id_src[2*RW-1:RW] == hist[j].rd;
                     if ((h0 || h1) && !(id_is_store && !h0 && h1 && j + 1 == LS - 1))
                        exp_stall = 1'b1;
                  end
               end
            end

            exp_mem = hist[1].valid && hist[1].st && hist[2].valid && hist[2].ld &&
                      hist[2].rd == hist[1].src1 && hist[1].src1 != 0;

            q_sel.push_back(exp_sel);
            q_stall.push_back(exp_stall);
            q_mem.push_back(exp_mem);
         end
         repeat (2) @(posedge clk);
         done = 1'b1;
      end
   end

   task automatic chk(input int cfg, input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL cfg%0d %s t=%0t actual=%0h expected=%0h", cfg, nm, $time, act, exp);
      end
   endtask

   // Single monitor: pops one expectation per config per cycle and owns the counters.
   int unsigned cyc = 0;
   always @(negedge clk) begin
      cyc++;
      if (g_cfg[0].q_sel.size() != 0) begin
         chk(0, "fwd_sel", 32'(g_cfg[0].fwd_sel), 32'(g_cfg[0].q_sel.pop_front()));
         chk(0, "load_use_stall", 32'(g_cfg[0].load_use_stall), 32'(g_cfg[0].q_stall.pop_front()));
         chk(0, "mem_fwd", 32'(g_cfg[0].mem_fwd), 32'(g_cfg[0].q_mem.pop_front()));
      end
      if (g_cfg[1].q_sel.size() != 0) begin
         chk(1, "fwd_sel", 32'(g_cfg[1].fwd_sel), 32'(g_cfg[1].q_sel.pop_front()));
         chk(1, "load_use_stall", 32'(g_cfg[1].load_use_stall), 32'(g_cfg[1].q_stall.pop_front()));
         chk(1, "mem_fwd", 32'(g_cfg[1].mem_fwd), 32'(g_cfg[1].q_mem.pop_front()));
      end
      if ((g_cfg[0].done && g_cfg[1].done) || cyc > 5000) begin
         if (!(g_cfg[0].done && g_cfg[1].done)) begin
            failures++;
            $display("FAIL timeout cycles=%0d actual=not_done expected=done", cyc);
         end
         if (checks < 12) begin
            failures++;
            $display("FAIL check_count actual=%0d expected>=12", checks);
         end
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

endmodule
